mac_sequencer: RTL

Control sequencer for the 8-bit MAC datapath. It accepts a dot-product job of `len` operand pairs and moves each pair from a valid/ready source into the operand register pair. It then clears and enables the accumulator in step with the one-cycle operand-register pipeline and presents the finished result through a valid/ready handshake. It sits between the operand source and the MAC datapath, and drives only enables; no data passes through it.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_elem_counter.sv | 46 ++++
 rtl/mac_sequencer.sv | 88 ++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC control sequencer: FSM state encoding and default widths.
package mac_pkg;

  localparam int unsigned LenWDefault = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClr    = 3'd1,
    StRun    = 3'd2,
    StDrain  = 3'd3,
    StResult = 3'd4
  } state_e;

endpackage

// File: rtl/mac_elem_counter.sv
// Job counters: loadable down-counter of pairs still to accept (with zero/last flags)
// and the matching up-counter of pairs accepted so far.
module mac_elem_counter #(
  parameter int unsigned LenW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [LenW-1:0] len_i,
  input  logic            dec_i,
  output logic            rem_zero_o,
  output logic            rem_last_o,
  output logic [LenW-1:0] elem_cnt_o
);

  logic [LenW-1:0] rem_q, rem_d;
  logic [LenW-1:0] elem_q, elem_d;

  // Loading a new job also clears the accepted count so it reads 0 from CLR onward.
  always_comb begin
    rem_d  = rem_q;
    elem_d = elem_q;
    if (load_i) begin
      rem_d  = len_i;
      elem_d = '0;
    end else if (dec_i) begin
      if (rem_q != '0) rem_d = rem_q - LenW'(1);
      if (elem_q != '1) elem_d = elem_q + LenW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      elem_q <= '0;
    end else begin
      rem_q  <= rem_d;
      elem_q <= elem_d;
    end
  end

  assign rem_zero_o = (rem_q == '0);
  assign rem_last_o = (rem_q == LenW'(1));
  assign elem_cnt_o = elem_q;

endmodule

// File: rtl/mac_sequencer.sv
// Control sequencer for the 8-bit MAC datapath: accepts a job of len operand pairs and
// drives operand load, accumulator clear/enable and the result handshake.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned LenW = LenWDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [LenW-1:0] len_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            ld_op_o,
  output logic            acc_clr_o,
  output logic            acc_en_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [LenW-1:0] elem_cnt_o
);

  state_e state_q, state_d;
  logic   in_ready_q, acc_clr_q, out_valid_q, busy_q;
  logic   pipe_q, done_q;
  logic   accept, handshake, load;
  logic   rem_zero, rem_last;

  assign accept    = in_valid_i & in_ready_q;
  assign handshake = out_valid_q & out_ready_i;
  assign load      = (state_q == StIdle) & start_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StClr;
      StClr:    state_d = rem_zero ? StResult : StRun;
      StRun:    if (accept && rem_last) state_d = StDrain;
      StDrain:  state_d = StResult;
      StResult: if (handshake) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pipe_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == StRun);
      acc_clr_q   <= (state_d == StClr);
      out_valid_q <= (state_d == StResult);
      busy_q      <= (state_d != StIdle);
      pipe_q      <= accept;
      done_q      <= handshake;
    end
  end

  mac_elem_counter #(
    .LenW (LenW)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .len_i      (len_i),
    .dec_i      (accept),
    .rem_zero_o (rem_zero),
    .rem_last_o (rem_last),
    .elem_cnt_o (elem_cnt_o)
  );

  assign in_ready_o  = in_ready_q;
  assign ld_op_o     = accept;
  assign acc_clr_o   = acc_clr_q;
  assign acc_en_o    = pipe_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
